instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 159 +++++++++++++++
 tb/tb_instr_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time instruction loader: parses a length-prefixed little-endian byte stream
// and writes one 32-bit word per cache write, holding the CPU for the whole load.
module instr_loader #(
    parameter int unsigned MAX_WORDS      = 1024,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        byte_ready_o,
    output logic        wr_instr_en_o,
    output logic [31:0] wr_instr_o,
    output logic [63:0] wr_addr_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     shift_q, shift_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [31:0]     instr_q, instr_d;
    logic [63:0]     addr_q, addr_d;
    logic            ready_q, wr_en_q, hold_q, done_q, err_q;

    logic            xfer;
    logic [31:0]     len_next;
    logic [31:0]     shift_next;
    logic            tmo_hit;

    assign xfer       = byte_valid_i & ready_q;
    assign len_next   = {byte_i, len_q[31:8]};
    assign shift_next = {byte_i, shift_q[31:8]};
    assign tmo_hit    = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        shift_d = shift_q;
        tmo_d   = tmo_q;
        instr_d = instr_q;
        addr_d  = addr_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start_i) begin
                    state_d = S_HDR;
                    bcnt_d  = 2'd0;
                    idx_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    len_d  = len_next;
                    bcnt_d = bcnt_q + 2'd1;
                    tmo_d  = '0;
                    if (bcnt_q == 2'd3) begin
                        if (len_next == 32'd0)
                            state_d = S_DONE;
                        else if (len_next > 32'(MAX_WORDS))
                            state_d = S_ERR;
                        else
                            state_d = S_DATA;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d = shift_next;
                    bcnt_d  = bcnt_q + 2'd1;
                    tmo_d   = '0;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        instr_d = shift_next;
                        addr_d  = BASE_ADDR + (64'(idx_q) << 2);
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            S_WRITE: begin
                if (32'(idx_q) == len_q - 32'd1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and outputs registered from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            bcnt_q  <= 2'd0;
            idx_q   <= '0;
            len_q   <= 32'd0;
            shift_q <= 32'd0;
            tmo_q   <= '0;
            instr_q <= 32'd0;
            addr_q  <= 64'd0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            tmo_q   <= tmo_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            ready_q <= (state_d == S_HDR) || (state_d == S_DATA);
            wr_en_q <= (state_d == S_WRITE);
            hold_q  <= (state_d == S_HDR) || (state_d == S_DATA) ||
                       (state_d == S_WRITE) || (state_d == S_ERR);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign byte_ready_o  = ready_q;
    assign wr_instr_en_o = wr_en_q;
    assign wr_instr_o    = instr_q;
    assign wr_addr_o     = addr_q;
    assign cpu_hold_o    = hold_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a cycle table for the basic two-word load plus
// hand-written sequences for random gaps, oversize header, timeout, N=0 and async reset.
module tb_instr_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_ready_o;
    logic        wr_instr_en_o;
    logic [31:0] wr_instr_o;
    logic [63:0] wr_addr_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wq_instr[$];
    logic [63:0] wq_addr[$];
    int          n_done = 0;
    bit          err_seen = 1'b0;

    instr_loader #(.MAX_WORDS(1024), .BASE_ADDR(64'h0), .TIMEOUT_CYCLES(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .wr_instr_en_o(wr_instr_en_o),
        .wr_instr_o   (wr_instr_o),
        .wr_addr_o    (wr_addr_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Record cache writes and status pulses mid-cycle
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (wr_instr_en_o) begin
                wq_instr.push_back(wr_instr_o);
                wq_addr.push_back(wr_addr_o);
            end
            if (done_o) n_done++;
            if (err_o) err_seen = 1'b1;
        end
    end

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  b;
        logic        ready;
        logic        en;
        logic        hold;
        logic        done;
        logic        err;
        logic [31:0] instr;
        logic [63:0] addr;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [7:0] b, logic rdy, logic en,
                                logic hold, logic dn, logic er, logic [31:0] ins,
                                logic [63:0] ad);
        vec_t r;
        r.start = s; r.valid = v; r.b = b; r.ready = rdy; r.en = en; r.hold = hold;
        r.done = dn; r.err = er; r.instr = ins; r.addr = ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_log();
        wq_instr.delete();
        wq_addr.delete();
        n_done = 0;
        err_seen = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        step();
        step();
        rst_ni = 1'b1;
        step();
        clear_log();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Present b after a random idle gap; holds valid until the loader accepts it
    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int unsigned gap;
        gap = $urandom_range(max_gap, 0);
        repeat (gap) begin
            byte_valid_i = 1'b0;
            byte_i = 8'($urandom);
            step();
        end
        byte_valid_i = 1'b1;
        byte_i = b;
        for (int k = 0; k < 40; k++) begin
            if (byte_ready_o) begin
                step();
                byte_valid_i = 1'b0;
                return;
            end
            step();
        end
        byte_valid_i = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL send_byte: byte %0h never accepted within 40 cycles", b);
    endtask

    task automatic chk_outs(input string tag, input logic rdy, input logic en, input logic hold,
                            input logic dn, input logic er);
        chk({tag, " ready"}, 64'(byte_ready_o), 64'(rdy));
        chk({tag, " wr_en"}, 64'(wr_instr_en_o), 64'(en));
        chk({tag, " hold"},  64'(cpu_hold_o), 64'(hold));
        chk({tag, " done"},  64'(done_o), 64'(dn));
        chk({tag, " err"},   64'(err_o), 64'(er));
    endtask

    logic [7:0] stream [12];
    vec_t       vecs [16];

    initial begin
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00};

        // Cycle table: inputs for the edge, outputs expected just after it
        vecs[0]  = mk(1, 0, 8'h00, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[1]  = mk(0, 1, 8'h02, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[2]  = mk(0, 1, 8'h00, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[3]  = mk(0, 1, 8'h00, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[4]  = mk(0, 1, 8'h00, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[5]  = mk(0, 1, 8'h13, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[6]  = mk(0, 1, 8'h05, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[7]  = mk(0, 1, 8'h10, 1, 0, 1, 0, 0, 32'h0, 64'h0);
        vecs[8]  = mk(0, 1, 8'h00, 0, 1, 1, 0, 0, 32'h00100513, 64'h0);
        vecs[9]  = mk(0, 1, 8'h93, 1, 0, 1, 0, 0, 32'h00100513, 64'h0);
        vecs[10] = mk(0, 1, 8'h93, 1, 0, 1, 0, 0, 32'h00100513, 64'h0);
        vecs[11] = mk(0, 1, 8'h05, 1, 0, 1, 0, 0, 32'h00100513, 64'h0);
        vecs[12] = mk(0, 1, 8'h20, 1, 0, 1, 0, 0, 32'h00100513, 64'h0);
        vecs[13] = mk(0, 1, 8'h00, 0, 1, 1, 0, 0, 32'h00200593, 64'h4);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 32'h00200593, 64'h4);
        vecs[15] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 32'h00200593, 64'h4);

        // Reset state
        do_reset();
        chk_outs("reset", 0, 0, 0, 0, 0);
        chk("reset instr", 64'(wr_instr_o), 64'h0);
        chk("reset addr", wr_addr_o, 64'h0);

        // Two-word load with valid held high
        for (int i = 0; i < 16; i++) begin
            start_i = vecs[i].start;
            byte_valid_i = vecs[i].valid;
            byte_i = vecs[i].b;
            step();
            chk_outs($sformatf("v%0d", i), vecs[i].ready, vecs[i].en, vecs[i].hold,
                     vecs[i].done, vecs[i].err);
            chk($sformatf("v%0d instr", i), 64'(wr_instr_o), 64'(vecs[i].instr));
            chk($sformatf("v%0d addr", i), wr_addr_o, vecs[i].addr);
        end
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        chk("table write count", 64'(wq_instr.size()), 64'd2);
        chk("table done count", 64'(n_done), 64'd1);

        // Same stream with random valid gaps
        do_reset();
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(stream[i], 3);
        for (int k = 0; k < 10 && n_done == 0; k++) step();
        chk("gaps done count", 64'(n_done), 64'd1);
        chk("gaps write count", 64'(wq_instr.size()), 64'd2);
        if (wq_instr.size() == 2) begin
            chk("gaps w0 instr", 64'(wq_instr[0]), 64'h00100513);
            chk("gaps w0 addr", wq_addr[0], 64'h0);
            chk("gaps w1 instr", 64'(wq_instr[1]), 64'h00200593);
            chk("gaps w1 addr", wq_addr[1], 64'h4);
        end
        chk("gaps no err", 64'(err_seen), 64'd0);

        // Oversize header N=1025
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk_outs("oversize", 0, 0, 1, 0, 1);
        step();
        chk("oversize err holds", 64'(err_o), 64'd1);
        chk("oversize writes", 64'(wq_instr.size()), 64'd0);
        pulse_start();
        chk_outs("restart", 1, 0, 1, 0, 0);

        // Timeout: transfer on the limit cycle wins, then 16 idle cycles trip ERR
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        repeat (15) step();
        chk("tmo pre-limit err", 64'(err_o), 64'd0);
        send_byte(8'h05, 0);
        chk_outs("tmo transfer wins", 1, 0, 1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) chk("tmo idle15 err", 64'(err_o), 64'd0);
        end
        chk_outs("tmo idle16", 0, 0, 1, 0, 1);
        chk("tmo writes", 64'(wq_instr.size()), 64'd0);

        // N=0 goes straight to DONE
        do_reset();
        pulse_start();
        repeat (4) send_byte(8'h00, 0);
        chk_outs("n0 done", 0, 0, 0, 1, 0);
        step();
        chk_outs("n0 idle", 0, 0, 0, 0, 0);
        chk("n0 writes", 64'(wq_instr.size()), 64'd0);

        // Asynchronous reset mid-DATA after one word written
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(stream[i], 0);
        chk("pre-rst instr", 64'(wr_instr_o), 64'h00100513);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_outs("async rst", 0, 0, 0, 0, 0);
        chk("async rst instr", 64'(wr_instr_o), 64'h0);
        chk("async rst addr", wr_addr_o, 64'h0);
        step();
        rst_ni = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
